// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and operand forwarding.
// Latency 1: an instruction accepted at edge N drives the ALU outputs after edge N.
// Backpressure: in_ready = ~stall; while stalled, the held instruction is frozen.
//
// Ports: clk/rst (async active-high); in_valid/in_ready plus in_* decoded fields;
//   stall, flush; exmem_* / memwb_* forwarding sources; alu_ctrl/alu_a/alu_b and
//   out_* towards EX.
// Build option ID_EX_FWD_EN: when defined, rs1/rs2 operands are forwarded from
//   EX/MEM and MEM/WB. When undefined, raw register-file data is used and the
//   extra output 'hazard' flags a pending forwarding match instead.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [4:0]            in_rd,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_we,
  input  logic [4:0]            exmem_rd,
  input  logic [DATA_WIDTH-1:0] exmem_data,
  input  logic                  memwb_we,
  input  logic [4:0]            memwb_rd,
  input  logic [DATA_WIDTH-1:0] memwb_data,
  output logic [CTRL_BITS-1:0]  alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  out_valid,
  output logic                  out_we,
  output logic                  out_branch,
  output logic                  out_illegal,
`ifndef ID_EX_FWD_EN
  output logic                  hazard,
`endif
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_store_data
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [CTRL_BITS-1:0] C_AND  = CTRL_BITS'(4'b0000);
  localparam logic [CTRL_BITS-1:0] C_XOR  = CTRL_BITS'(4'b0001);
  localparam logic [CTRL_BITS-1:0] C_ADD  = CTRL_BITS'(4'b0010);
  localparam logic [CTRL_BITS-1:0] C_OR   = CTRL_BITS'(4'b0011);
  localparam logic [CTRL_BITS-1:0] C_SGE  = CTRL_BITS'(4'b0101);
  localparam logic [CTRL_BITS-1:0] C_SUB  = CTRL_BITS'(4'b0110);
  localparam logic [CTRL_BITS-1:0] C_SLT  = CTRL_BITS'(4'b0111);
  localparam logic [CTRL_BITS-1:0] C_ILL  = CTRL_BITS'(4'b1000);
  localparam logic [CTRL_BITS-1:0] C_SGEU = CTRL_BITS'(4'b1101);
  localparam logic [CTRL_BITS-1:0] C_SLTU = CTRL_BITS'(4'b1111);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
  } stage_t;

  stage_t stage_q, stage_d;
  logic   valid_q, valid_d;

  assign in_ready = ~stall;

  // Flush wins over everything; otherwise an un-stalled edge either takes a
  // new instruction or drains the stage. Payload is only replaced on capture.
  always_comb begin
    valid_d = valid_q;
    stage_d = stage_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        stage_d = '{pc: in_pc, rs1_data: in_rs1_data, rs2_data: in_rs2_data,
                    imm: in_imm, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                    opcode: in_opcode, funct3: in_funct3, funct7b5: in_funct7b5};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  // Forwarding matches against the held source registers; x0 never matches.
  logic ex_m1, wb_m1, ex_m2, wb_m2;
  assign ex_m1 = exmem_we && (exmem_rd == stage_q.rs1) && (stage_q.rs1 != 5'd0);
  assign wb_m1 = memwb_we && (memwb_rd == stage_q.rs1) && (stage_q.rs1 != 5'd0);
  assign ex_m2 = exmem_we && (exmem_rd == stage_q.rs2) && (stage_q.rs2 != 5'd0);
  assign wb_m2 = memwb_we && (memwb_rd == stage_q.rs2) && (stage_q.rs2 != 5'd0);

  logic [DATA_WIDTH-1:0] rs1_op, rs2_op;
`ifdef ID_EX_FWD_EN
  // EX/MEM is the younger result, so it takes precedence over MEM/WB.
  assign rs1_op = ex_m1 ? exmem_data : (wb_m1 ? memwb_data : stage_q.rs1_data);
  assign rs2_op = ex_m2 ? exmem_data : (wb_m2 ? memwb_data : stage_q.rs2_data);
`else
  assign rs1_op = stage_q.rs1_data;
  assign rs2_op = stage_q.rs2_data;
  assign hazard = valid_q && (ex_m1 || wb_m1 || ex_m2 || wb_m2);
  // Forwarding data ports stay on the interface but carry nothing in this build.
  logic unused_fwd_data;
  assign unused_fwd_data = ^{exmem_data, memwb_data};
`endif

  // Shared R/I funct3 table; returns {illegal, ctrl}. Shifts are unsupported.
  function automatic logic [CTRL_BITS:0] alu_f3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return {1'b0, (sub ? C_SUB : C_ADD)};
      3'b111:  return {1'b0, C_AND};
      3'b110:  return {1'b0, C_OR};
      3'b100:  return {1'b0, C_XOR};
      3'b010:  return {1'b0, C_SLT};
      3'b011:  return {1'b0, C_SLTU};
      default: return {1'b1, C_ILL};
    endcase
  endfunction

  logic [CTRL_BITS-1:0]  ctrl_raw;
  logic [DATA_WIDTH-1:0] a_raw, b_raw;
  logic                  we_raw, br_raw, ill_raw;
  logic [CTRL_BITS:0]    f3_res;

  always_comb begin
    ctrl_raw = C_ADD;
    a_raw    = rs1_op;
    b_raw    = rs2_op;
    we_raw   = 1'b0;
    br_raw   = 1'b0;
    ill_raw  = 1'b0;
    f3_res   = '0;
    case (stage_q.opcode)
      OP_R: begin
        f3_res   = alu_f3(stage_q.funct3, stage_q.funct7b5);
        ill_raw  = f3_res[CTRL_BITS];
        ctrl_raw = f3_res[CTRL_BITS-1:0];
        we_raw   = 1'b1;
      end
      OP_I: begin
        f3_res   = alu_f3(stage_q.funct3, 1'b0);
        ill_raw  = f3_res[CTRL_BITS];
        ctrl_raw = f3_res[CTRL_BITS-1:0];
        b_raw    = stage_q.imm;
        we_raw   = 1'b1;
      end
      OP_B: begin
        br_raw = 1'b1;
        case (stage_q.funct3)
          3'b000, 3'b001: ctrl_raw = C_SUB;
          3'b100:         ctrl_raw = C_SLT;
          3'b101:         ctrl_raw = C_SGE;
          3'b110:         ctrl_raw = C_SLTU;
          3'b111:         ctrl_raw = C_SGEU;
          default:        ill_raw  = 1'b1;
        endcase
      end
      OP_L:     begin b_raw = stage_q.imm; we_raw = 1'b1; end
      OP_S:     begin b_raw = stage_q.imm; end
      OP_LUI:   begin a_raw = '0; b_raw = stage_q.imm; we_raw = 1'b1; end
      OP_AUIPC: begin a_raw = stage_q.pc; b_raw = stage_q.imm; we_raw = 1'b1; end
      OP_JAL:   begin a_raw = stage_q.pc; b_raw = DATA_WIDTH'(4); we_raw = 1'b1; end
      default:  ill_raw = 1'b1;
    endcase
    if (ill_raw) begin
      ctrl_raw = C_ILL;
      we_raw   = 1'b0;
      br_raw   = 1'b0;
    end
  end

  // An empty stage presents all-zero outputs so EX sees a clean bubble.
  assign out_valid      = valid_q;
  assign alu_ctrl       = valid_q ? ctrl_raw : '0;
  assign alu_a          = valid_q ? a_raw    : '0;
  assign alu_b          = valid_q ? b_raw    : '0;
  assign out_we         = valid_q & we_raw;
  assign out_branch     = valid_q & br_raw;
  assign out_illegal    = valid_q & ill_raw;
  assign out_rd         = valid_q ? stage_q.rd : 5'd0;
  assign out_pc         = valid_q ? stage_q.pc : '0;
  assign out_store_data = valid_q ? rs2_op     : '0;

endmodule
